recon_desc_arbiter: RTL and testbench
=====================================

# recon_desc_arbiter

Round-robin scheduler that shares one DMA read-descriptor engine among `PORTS` reconfiguration requesters, each requesting a bitstream load by address/length. Keeps exactly one descriptor outstanding, matches the returning status by tag, and enforces a configurable timeout. Reports a per-request completion code back to the owning port. Sits between the reconfiguration controllers and the DMA read descriptor/status interface.

## Interface
Parameters:
- `PORTS`, 4, number of requesters (2..16)
- `ADDR_WIDTH`, 34, descriptor address width
- `LEN_WIDTH`, 20, descriptor length width (bytes)
- `TAG_WIDTH`, 8, descriptor tag width; must exceed `$clog2(PORTS)`
- `MAX_LEN`, 2**20-1, largest legal length
- `TIMEOUT_WIDTH`, 16, width of `cfg_timeout`

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock
- `rst_n` in 1: asynchronous active-low reset
- `req_addr` in PORTS*ADDR_WIDTH: per-port bitstream address, port i at slice i
- `req_len` in PORTS*LEN_WIDTH: per-port length in bytes
- `req_valid` in PORTS: per-port request
- `req_ready` out PORTS: per-port accept
- `cpl_valid` out PORTS: one-cycle completion pulse to owning port
- `cpl_status` out 2: 00 ok, 01 DMA error, 10 timeout, 11 bad length; valid with `cpl_valid`
- `m_axis_read_desc_addr` out ADDR_WIDTH; `m_axis_read_desc_len` out LEN_WIDTH; `m_axis_read_desc_tag` out TAG_WIDTH
- `m_axis_read_desc_valid` out 1; `m_axis_read_desc_ready` in 1
- `s_axis_read_desc_status_tag` in TAG_WIDTH; `s_axis_read_desc_status_error` in 4; `s_axis_read_desc_status_valid` in 1
- `cfg_timeout` in TIMEOUT_WIDTH: WAIT cycles before timeout; 0 disables
- `busy` out 1: state != IDLE
- `stale_count` out 16: saturating count of unmatched status beats

## Operation
- States: IDLE, ISSUE, WAIT, COMPLETE.
- IDLE: winner = first asserted `req_valid` scanning from `rr_ptr` upward with wrap. `req_ready[winner]` asserts combinationally; at most one `req_ready` bit is ever set; none outside IDLE. On handshake, latch addr, len, and port.
  - len == 0 or len > MAX_LEN → COMPLETE with status 11; no descriptor issued.
  - Otherwise → ISSUE; `seq` increments.
- Tag = {seq, port}: port in the low `$clog2(PORTS)` bits, `seq` in the remaining bits, wrapping modulo 2**(TAG_WIDTH-$clog2(PORTS)).
- ISSUE: `m_axis_read_desc_valid`=1, with addr/len/tag held stable until `ready`. On handshake → WAIT and clear `wait_cnt`.
- WAIT: a status beat with tag == the issued tag → COMPLETE, status 01 if error != 0, else 00.
  - Without a match: if `cfg_timeout` != 0 and `wait_cnt` == `cfg_timeout`-1 → COMPLETE with status 10; otherwise `wait_cnt`++.
- COMPLETE: `cpl_valid[port]`=1 for one cycle, `cpl_status` driven. `rr_ptr` ← (port+1) mod PORTS. → IDLE.
- A status beat in any state other than a matching WAIT increments `stale_count` (saturates at 0xFFFF). A late status after a timeout carries the old tag and is therefore counted stale.
- `cfg_timeout` is sampled continuously; a change during WAIT takes effect immediately.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `rr_ptr`=0, `seq`=0, `wait_cnt`=0, `stale_count`=0. All outputs 0, including `m_axis_read_desc_valid`, which drops immediately on assertion. Reset mid-ISSUE/WAIT abandons the request with no completion.
- Accept at cycle T → `m_axis_read_desc_valid` high at T+1. Bad length → `cpl_valid` at T+1.
- Descriptor handshake at cycle D → WAIT from D+1.
- Matching status at cycle S → `cpl_valid` at S+1.
- Timeout: WAIT lasts exactly `cfg_timeout` cycles → `cpl_valid` on the next cycle.
- A match on the timeout cycle wins; status is 00 or 01.
- Back-to-back: next accept possible at the cycle after `cpl_valid` (IDLE); minimum request-to-request spacing is 4 cycles.
- `req_valid` may drop without acceptance; no grant is stored.

## Test plan
- Single request: port 2, addr 0x1_0000_0000, len 0x4000, cfg_timeout=100, ready tied 1 → desc tag 0x06 (seq 1, port 2) at T+1. Status tag 0x06, error 0 at D+5 → `cpl_valid[2]`, status 00, one cycle later.
- Round-robin: all 4 ports requesting continuously with immediate status → grant order 0,1,2,3,0; no port is granted twice in a row.
- Bad length: port 1, len 0 and then len MAX_LEN+1 → `cpl_status` 11 at T+1 each time; `m_axis_read_desc_valid` never asserts.
- Timeout: cfg_timeout=8, no status → `cpl_status` 10 exactly 9 cycles after descriptor handshake. A later status with the old tag → `stale_count` 1; next request uses seq+1.
- DMA error and stale: wrong-tag status in WAIT → ignored, `stale_count`++. Then matching tag with error 4'h3 → status 01.
- Reset mid-WAIT: deassert `rst_n` for 1 cycle → all outputs 0 immediately; next request goes to port 0 first with tag seq 1.

Source files
------------

// File: rtl/recon_desc_arbiter.sv
// recon_desc_arbiter: round-robin sharing of one DMA read-descriptor engine
// among PORTS reconfiguration requesters, one descriptor outstanding.
module recon_desc_arbiter #(
    parameter int PORTS         = 4,
    parameter int ADDR_WIDTH    = 34,
    parameter int LEN_WIDTH     = 20,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_LEN       = 2**20-1,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]  req_len,
    input  logic [PORTS-1:0]            req_valid,
    output logic [PORTS-1:0]            req_ready,
    output logic [PORTS-1:0]            cpl_valid,
    output logic [1:0]                  cpl_status,
    output logic [ADDR_WIDTH-1:0]       m_axis_read_desc_addr,
    output logic [LEN_WIDTH-1:0]        m_axis_read_desc_len,
    output logic [TAG_WIDTH-1:0]        m_axis_read_desc_tag,
    output logic                        m_axis_read_desc_valid,
    input  logic                        m_axis_read_desc_ready,
    input  logic [TAG_WIDTH-1:0]        s_axis_read_desc_status_tag,
    input  logic [3:0]                  s_axis_read_desc_status_error,
    input  logic                        s_axis_read_desc_status_valid,
    input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
    output logic                        busy,
    output logic [15:0]                 stale_count
);
    localparam int PW = $clog2(PORTS);
    localparam int SW = TAG_WIDTH - PW;
    localparam logic [LEN_WIDTH:0] MAX_LEN_W = (LEN_WIDTH+1)'(MAX_LEN);
    localparam logic [PW:0] PORTS_W = (PW+1)'(PORTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            port_q;
    logic [SW-1:0]            seq_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    logic [1:0]               st_q;

    logic                     grant_any;
    logic [PW-1:0]            grant_idx;
    logic [PW:0]              scan;
    logic [LEN_WIDTH-1:0]     sel_len;
    logic                     len_bad;
    logic                     tag_match;
    logic                     timeout_hit;

    // Scan downward so the port closest to rr_ptr is the last (winning) write.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = PORTS-1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan >= PORTS_W) begin
                scan = scan - PORTS_W;
            end
            if (req_valid[scan[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[PW-1:0];
            end
        end
    end

    assign sel_len   = req_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
    assign len_bad   = (sel_len == '0) || ({1'b0, sel_len} > MAX_LEN_W);
    assign tag_match = s_axis_read_desc_status_valid &&
                       (s_axis_read_desc_status_tag == {seq_q, port_q});
    assign timeout_hit = (cfg_timeout != '0) &&
                         (wait_cnt == cfg_timeout - 1'b1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = len_bad ? S_COMPLETE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_axis_read_desc_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tag_match || timeout_hit) begin
                    state_d = S_COMPLETE;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            port_q      <= '0;
            seq_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wait_cnt    <= '0;
            st_q        <= '0;
            stale_count <= '0;
        end else begin
            if (s_axis_read_desc_status_valid &&
                !(state_q == S_WAIT && tag_match) &&
                stale_count != 16'hFFFF) begin
                stale_count <= stale_count + 16'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        port_q <= grant_idx;
                        addr_q <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        len_q  <= sel_len;
                        if (len_bad) begin
                            st_q <= 2'b11;
                        end else begin
                            seq_q <= seq_q + 1'b1;
                        end
                    end
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    // A match on the timeout cycle takes priority.
                    if (tag_match) begin
                        st_q <= (s_axis_read_desc_status_error != 4'd0) ?
                                2'b01 : 2'b00;
                    end else if (timeout_hit) begin
                        st_q <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_COMPLETE: begin
                    rr_ptr <= (port_q == PW'(PORTS-1)) ? '0 : port_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        cpl_valid = '0;
        if (state_q == S_IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == S_COMPLETE) begin
            cpl_valid[port_q] = 1'b1;
        end
    end

    assign cpl_status             = (state_q == S_COMPLETE) ? st_q : 2'b00;
    assign m_axis_read_desc_addr  = addr_q;
    assign m_axis_read_desc_len   = len_q;
    assign m_axis_read_desc_tag   = {seq_q, port_q};
    assign m_axis_read_desc_valid = (state_q == S_ISSUE);
    assign busy                   = (state_q != S_IDLE);

endmodule

// File: tb/tb_recon_desc_arbiter.sv
// tb_recon_desc_arbiter: randomized transactions against a
// transaction-level model of grant order, tags, status and stale count.
module tb_recon_desc_arbiter;
    localparam int P   = 4;
    localparam int AW  = 34;
    localparam int LW  = 20;
    localparam int TW  = 8;
    localparam int TOW = 16;
    localparam int ML  = 'hFFF00;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P*AW-1:0] req_addr;
    logic [P*LW-1:0] req_len;
    logic [P-1:0]    req_valid = '0;
    logic [P-1:0]    req_ready;
    logic [P-1:0]    cpl_valid;
    logic [1:0]      cpl_status;
    logic [AW-1:0]   d_addr;
    logic [LW-1:0]   d_len;
    logic [TW-1:0]   d_tag;
    logic            d_valid;
    logic            d_ready = 1'b0;
    logic [TW-1:0]   s_tag = '0;
    logic [3:0]      s_err = '0;
    logic            s_valid = 1'b0;
    logic [TOW-1:0]  cfg_timeout = '0;
    logic            busy;
    logic [15:0]     stale_count;

    logic [AW-1:0] a_m [P];
    logic [LW-1:0] l_m [P];

    int total = 0;
    int bad   = 0;
    int rr_m, seq_m, stale_m;

    for (genvar g = 0; g < P; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = a_m[g];
        assign req_len[g*LW +: LW]  = l_m[g];
    end

    always #5 clk = ~clk;

    recon_desc_arbiter #(
        .PORTS(P), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .TAG_WIDTH(TW), .MAX_LEN(ML), .TIMEOUT_WIDTH(TOW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_len(req_len),
        .req_valid(req_valid), .req_ready(req_ready),
        .cpl_valid(cpl_valid), .cpl_status(cpl_status),
        .m_axis_read_desc_addr(d_addr), .m_axis_read_desc_len(d_len),
        .m_axis_read_desc_tag(d_tag), .m_axis_read_desc_valid(d_valid),
        .m_axis_read_desc_ready(d_ready),
        .s_axis_read_desc_status_tag(s_tag),
        .s_axis_read_desc_status_error(s_err),
        .s_axis_read_desc_status_valid(s_valid),
        .cfg_timeout(cfg_timeout), .busy(busy), .stale_count(stale_count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        s_valid = 1'b0;
        s_tag   = '0;
        s_err   = '0;
    endtask

    // One full request: mask held throughout, rdly cycles of !ready,
    // status match md cycles into WAIT (-1 none), wrong tag at wd.
    task automatic do_txn(input logic [P-1:0] mask, input int rdly,
                          input int tmo, input int md, input logic [3:0] err,
                          input int wd, input bit late);
        int win, endc;
        bit badlen, hit;
        logic [TW-1:0] tag;
        logic [1:0] st;
        win = -1;
        for (int k = 0; k < P; k++) begin
            if (win < 0 && mask[(rr_m + k) % P]) win = (rr_m + k) % P;
        end
        next_cyc();
        cfg_timeout = TOW'(tmo);
        req_valid = mask;
        #1;
        chk("busy_idle", busy, 0);
        chk("grant", req_ready, 64'(1) << win);
        badlen = (l_m[win] == 0) || (l_m[win] > ML);
        next_cyc();
        #1;
        chk("ready_busy", req_ready, 0);
        chk("busy", busy, 1);
        if (badlen) begin
            chk("cpl_badlen", cpl_valid, 64'(1) << win);
            chk("st_badlen", cpl_status, 3);
            chk("desc_badlen", d_valid, 0);
        end else begin
            seq_m = (seq_m + 1) % 64;
            tag = TW'((seq_m << 2) | win);
            for (int i = 0; i <= rdly; i++) begin
                if (i > 0) next_cyc();
                d_ready = (i == rdly);
                #1;
                chk("desc_valid", d_valid, 1);
                chk("desc_addr", d_addr, a_m[win]);
                chk("desc_len", d_len, l_m[win]);
                chk("desc_tag", d_tag, tag);
            end
            next_cyc();
            d_ready = 1'b0;
            hit = (md >= 0) && (tmo == 0 || md <= tmo - 1);
            endc = hit ? md : tmo - 1;
            for (int c = 0; c <= endc; c++) begin
                if (c > 0) next_cyc();
                if (c == md) begin
                    s_valid = 1'b1; s_tag = tag; s_err = err;
                end else if (c == wd) begin
                    s_valid = 1'b1; s_tag = tag ^ 8'h80; stale_m++;
                end
                #1;
                chk("wait_cpl", cpl_valid, 0);
                chk("wait_desc", d_valid, 0);
            end
            next_cyc();
            if (!hit && late) begin
                s_valid = 1'b1; s_tag = tag; stale_m++;
            end
            #1;
            st = hit ? ((err != 0) ? 2'b01 : 2'b00) : 2'b10;
            chk("cpl", cpl_valid, 64'(1) << win);
            chk("cpl_status", cpl_status, st);
        end
        rr_m = (win + 1) % P;
        next_cyc();
        req_valid = '0;
        #1;
        chk("busy_after", busy, 0);
        chk("cpl_after", cpl_valid, 0);
        chk("stale", stale_count, stale_m);
    endtask

    function automatic logic [LW-1:0] rand_len();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return LW'($urandom_range(ML + 1, 'hFFFFF));
        if (r == 2) return LW'(ML);
        return LW'($urandom_range(1, ML));
    endfunction

    initial begin
        int tmo, md, wd;
        rr_m = 0; seq_m = 0; stale_m = 0;
        for (int p = 0; p < P; p++) begin
            a_m[p] = {2'b00, 32'($urandom)};
            l_m[p] = LW'(16'h100 * (p + 1));
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_desc", d_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpl", cpl_valid, 0);
        chk("rst_stale", stale_count, 0);
        chk("rst_tag", d_tag, 0);
        rst_n = 1'b1;

        a_m[2] = 34'h1_0000_0000;
        l_m[2] = 20'h4000;
        do_txn(4'b0100, 0, 100, 4, 4'h0, -1, 0);

        for (int i = 0; i < 5; i++) do_txn(4'hF, 0, 50, 0, 4'h0, -1, 0);

        l_m[1] = '0;
        do_txn(4'b0010, 0, 10, 0, 4'h0, -1, 0);
        l_m[1] = LW'(ML + 1);
        do_txn(4'b0010, 0, 10, 0, 4'h0, -1, 0);
        l_m[1] = LW'(ML);
        do_txn(4'b0010, 1, 10, 2, 4'h0, -1, 0);

        do_txn(4'b0001, 0, 8, -1, 4'h0, -1, 1);
        do_txn(4'b1000, 2, 20, 6, 4'h3, 2, 0);
        do_txn(4'b0100, 0, 5, 4, 4'h0, -1, 0);
        do_txn(4'b0100, 0, 1, -1, 4'h0, -1, 0);

        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < P; p++) begin
                a_m[p] = {2'($urandom), 32'($urandom)};
                l_m[p] = rand_len();
            end
            tmo = $urandom_range(0, 12);
            md  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 14);
            if (tmo == 0 && md < 0) md = $urandom_range(0, 10);
            wd  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
            if (wd == md) wd = -1;
            do_txn(P'($urandom_range(1, 15)), $urandom_range(0, 3), tmo, md,
                   ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                   wd, 1'($urandom));
        end

        for (int p = 0; p < P; p++) l_m[p] = 20'h800;
        do_txn(4'b0001, 0, 10, 0, 4'h0, -1, 0);
        next_cyc();
        req_valid = 4'b1000;
        #1;
        chk("abandon_grant", req_ready, 4'b1000);
        next_cyc();
        req_valid = '0;
        #1;
        chk("abandon_issue", d_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_desc", d_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_stale", stale_count, 0);
        chk("arst_cpl", cpl_valid, 0);
        next_cyc();
        rst_n = 1'b1;
        rr_m = 0; seq_m = 0; stale_m = 0;
        do_txn(4'b1001, 0, 10, 1, 4'h0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
